// File: rtl/sram_master.sv
// sram_master: host-facing burst initiator for a single-port SRAM with a
// four-phase valid/ready handshake. Each beat raises valid, waits for
// ready high, drops valid, then waits for ready low before the next beat.
// Write data streams in through wd_*, and read data streams out through rsp_*.
// A target that never changes the level of ready ends the burst with an err pulse.
module sram_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  // host command interface
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [3:0]        cmd_len,
  // host write data
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  // host read response
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  // status
  output logic              done,
  output logic              err,
  output logic              busy,
  // SRAM side
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_rd,
  output logic              valid,
  input  logic              ready,
  input  logic [DATA_W-1:0] rd_data
);

  typedef enum logic [2:0] {IDLE, FETCH, REQ, RELEASE, RESP} state_t;

  localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        is_wr_q;
  logic [3:0]  len_q;
  logic [3:0]  beat_q;
  logic [7:0]  tcnt_q;

  logic        last_beat;
  logic        tcnt_hit;
  logic        cmd_fire;
  logic        data_fire;
  logic        ack_seen;
  logic        idle_seen;
  logic        rsp_fire;
  logic        abort;

  assign last_beat = (beat_q == len_q);
  assign tcnt_hit  = (tcnt_q == TCNT_LAST);

  // A ready level left high by an aborted or reset burst must never look like
  // the acknowledge of a new command, so a command is accepted only while ready is low.
  assign cmd_ready = (state_q == IDLE) && !ready;
  assign wd_ready  = (state_q == FETCH);
  assign busy      = (state_q != IDLE);

  // Next-state logic and the one-cycle event strobes that drive the datapath.
  always_comb begin
    // NOTE: every signal assigned in this block receives a default first, so that no path infers a latch.
    state_d   = state_q;
    cmd_fire  = 1'b0;
    data_fire = 1'b0;
    ack_seen  = 1'b0;
    idle_seen = 1'b0;
    rsp_fire  = 1'b0;
    abort     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cmd_fire = 1'b1;
          state_d  = cmd_wr ? FETCH : REQ;
        end
      end
      FETCH: begin
        // The host may take as long as it likes; no timeout applies here.
        if (wd_valid) begin
          data_fire = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (ready) begin
          ack_seen = 1'b1;
          state_d  = RELEASE;
        end else if (tcnt_hit) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      RELEASE: begin
        if (!ready) begin
          idle_seen = 1'b1;
          if (!is_wr_q)       state_d = RESP;
          else if (last_beat) state_d = IDLE;
          else                state_d = FETCH;
        end else if (tcnt_hit) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_fire = 1'b1;
          state_d  = last_beat ? IDLE : REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // The wait counter restarts on every state change and counts cycles spent
  // waiting for a ready level change in REQ or RELEASE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt_q <= '0;
    end else if (state_d != state_q) begin
      tcnt_q <= '0;
    end else if (state_q == REQ || state_q == RELEASE) begin
      tcnt_q <= tcnt_q + 8'd1;
    end
  end

  // Burst bookkeeping, SRAM request outputs, host response, and status pulses.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (!rst) begin
      is_wr_q   <= 1'b0;
      len_q     <= '0;
      beat_q    <= '0;
      addr      <= '0;
      wr_data   <= '0;
      wr_rd     <= 1'b0;
      valid     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_last  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;

      if (cmd_fire) begin
        is_wr_q <= cmd_wr;
        len_q   <= cmd_len;
        beat_q  <= '0;
        addr    <= cmd_addr;
        wr_rd   <= cmd_wr;
        // A read has nothing to fetch, so its request starts immediately.
        if (!cmd_wr) valid <= 1'b1;
      end

      if (data_fire) begin
        wr_data <= wd_data;
        valid   <= 1'b1;
      end

      if (ack_seen) begin
        valid <= 1'b0;
        if (!is_wr_q) rsp_data <= rd_data;
      end

      if (idle_seen) begin
        if (!is_wr_q) begin
          rsp_valid <= 1'b1;
          rsp_last  <= last_beat;
        end else if (last_beat) begin
          done <= 1'b1;
        end else begin
          beat_q <= beat_q + 4'd1;
          addr   <= addr + ADDR_W'(1);
        end
      end

      if (rsp_fire) begin
        rsp_valid <= 1'b0;
        rsp_last  <= 1'b0;
        if (last_beat) begin
          done <= 1'b1;
        end else begin
          beat_q <= beat_q + 4'd1;
          addr   <= addr + ADDR_W'(1);
          valid  <= 1'b1;
        end
      end

      // An unresponsive target drops the rest of the burst; done never follows.
      if (abort) begin
        valid     <= 1'b0;
        rsp_valid <= 1'b0;
        rsp_last  <= 1'b0;
        err       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_master.sv
// Directed testbench for sram_master. It contains a behavioural SRAM responder,
// a reference memory that predicts read data, and queues of expected SRAM
// addresses and read responses that are popped as the DUT produces them.
module tb_sram_master;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_wr = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [3:0]        cmd_len = '0;
  logic              wd_valid = 1'b0;
  logic              wd_ready;
  logic [DATA_W-1:0] wd_data = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;
  logic              done;
  logic              err;
  logic              busy;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_rd;
  logic              valid;
  logic              ready = 1'b0;
  logic [DATA_W-1:0] rd_data = '0;

  sram_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .done(done), .err(err), .busy(busy),
    .addr(addr), .wr_data(wr_data), .wr_rd(wr_rd), .valid(valid),
    .ready(ready), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // The responder mode selects a normal SRAM (0), ready tied low (1), or ready tied high (2).
  int sram_mode = 0;
  logic [DATA_W-1:0] mem     [256];
  logic [DATA_W-1:0] ref_mem [256];
  logic [ADDR_W-1:0] addr_log [$];
  logic [ADDR_W-1:0] exp_addr [$];
  logic [DATA_W-1:0] exp_rsp  [$];
  logic prev_v = 1'b0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int rsp_cyc  = 0;
  int wd_cnt   = 0;

  // SRAM responder: ready follows valid one cycle later, and the access repeats while valid is held.
  always @(posedge clk) begin
    case (sram_mode)
      1: ready <= 1'b0;
      2: ready <= 1'b1;
      default: begin
        ready <= valid;
        if (valid) begin
          if (wr_rd) mem[addr] <= wr_data;
          rd_data <= mem[addr];
        end
      end
    endcase
  end

  // Event monitor: logs each new SRAM request address and counts pulses and handshakes.
  always @(posedge clk) begin
    prev_v <= valid;
    if (valid && !prev_v) addr_log.push_back(addr);
    if (done) done_cnt <= done_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
    if (rsp_valid) rsp_cyc <= rsp_cyc + 1;
    if (wd_valid && wd_ready) wd_cnt <= wd_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic wr, input logic [ADDR_W-1:0] a, input logic [3:0] l);
    int n = 0;
    logic [ADDR_W-1:0] ba;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    check("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_len = l;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i <= int'(l); i++) begin
      ba = a + ADDR_W'(i);
      exp_addr.push_back(ba);
      if (!wr) exp_rsp.push_back(ref_mem[ba]);
    end
  endtask

  task automatic write_beat(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input int stall);
    int n = 0;
    while (!wd_ready && n < 100) begin @(negedge clk); n++; end
    check("wd_ready_wait", wd_ready, 1);
    for (int i = 0; i < stall; i++) begin
      check("fetch_stall_valid", valid, 0);
      check("fetch_stall_err", err, 0);
      @(negedge clk);
    end
    wd_valid = 1'b1; wd_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    wd_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 200) begin @(negedge clk); n++; end
    check("done_pulse", done, 1);
  endtask

  task automatic read_beat(input logic last, input int stall, output int lat);
    logic [DATA_W-1:0] e;
    lat = 0;
    while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
    check("rsp_valid_wait", rsp_valid, 1);
    e = (exp_rsp.size() > 0) ? exp_rsp[0] : 'x;
    for (int i = 0; i < stall; i++) begin
      check("stall_rsp_valid", rsp_valid, 1);
      check("stall_rsp_data", rsp_data, e);
      check("stall_no_sram_req", valid, 0);
      @(negedge clk);
    end
    check("rsp_queue_nonempty", exp_rsp.size() > 0, 1);
    if (exp_rsp.size() > 0) e = exp_rsp.pop_front();
    check("rsp_data", rsp_data, e);
    check("rsp_last", rsp_last, last);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (last) check("read_done", done, 1);
  endtask

  task automatic compare_addrs();
    logic [ADDR_W-1:0] ea, aa;
    check("addr_count", addr_log.size(), exp_addr.size());
    while (addr_log.size() > 0 && exp_addr.size() > 0) begin
      aa = addr_log.pop_front();
      ea = exp_addr.pop_front();
      check("sram_addr", aa, ea);
    end
    addr_log.delete();
    exp_addr.delete();
  endtask

  initial begin
    int lat, n, d0, e0, w0, r0;
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_addr", addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    rst = 1'b1;
    @(negedge clk);

    // Single write of 0xBEEF to 0x10, then read it back
    w0 = wd_cnt;
    send_cmd(1'b1, 8'h10, 4'd0);
    check("write_wr_rd", wr_rd, 1);
    write_beat(8'h10, 16'hBEEF, 0);
    wait_done(n);
    check("write_beat_cycles", n, 4);
    @(negedge clk);
    check("write_wd_handshakes", wd_cnt - w0, 1);
    send_cmd(1'b0, 8'h10, 4'd0);
    read_beat(1'b1, 0, lat);
    check("read_first_rsp_latency", lat, 4);
    @(negedge clk);
    compare_addrs();

    // Four-beat write burst that wraps from 0xFE, then a read burst over the same range
    send_cmd(1'b1, 8'hFE, 4'd3);
    for (int i = 0; i < 4; i++) begin
      a = 8'hFE + ADDR_W'(i);
      write_beat(a, DATA_W'(i + 1), 0);
    end
    wait_done(n);
    @(negedge clk);
    compare_addrs();
    send_cmd(1'b0, 8'hFE, 4'd3);
    for (int i = 0; i < 4; i++) read_beat(i == 3, 0, lat);
    @(negedge clk);
    compare_addrs();

    // Two-beat read with the host stalling the response for 10 cycles per beat
    send_cmd(1'b0, 8'hFE, 4'd1);
    read_beat(1'b0, 10, lat);
    read_beat(1'b1, 10, lat);
    @(negedge clk);
    compare_addrs();

    // Write with data delayed 7 cycles; a command offered while busy is ignored
    e0 = err_cnt;
    send_cmd(1'b1, 8'h40, 4'd0);
    check("busy_cmd_ready", cmd_ready, 0);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 8'h99;
    @(negedge clk);
    cmd_valid = 1'b0;
    write_beat(8'h40, 16'h1234, 7);
    wait_done(n);
    send_cmd(1'b0, 8'h40, 4'd0);
    read_beat(1'b1, 0, lat);
    @(negedge clk);
    check("stall_write_no_err", err_cnt - e0, 0);
    compare_addrs();

    // Ready tied low: a read at 0x20 times out
    sram_mode = 1;
    @(negedge clk);
    d0 = done_cnt; r0 = rsp_cyc; e0 = err_cnt;
    send_cmd(1'b0, 8'h20, 4'd0);
    exp_rsp.delete();
    exp_addr.delete();
    n = 0;
    while (valid && n < 100) begin n++; @(negedge clk); end
    check("timeout_valid_cycles", n, TIMEOUT);
    check("timeout_err", err, 1);
    check("timeout_idle", busy, 0);
    check("timeout_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    check("timeout_err_one_cycle", err, 0);
    @(negedge clk);
    check("timeout_err_count", err_cnt - e0, 1);
    check("timeout_no_done", done_cnt - d0, 0);
    check("timeout_no_rsp", rsp_cyc - r0, 0);
    sram_mode = 0;
    addr_log.delete();
    repeat (2) @(negedge clk);

    // Reset during RELEASE of beat 2 of a 4-beat write while ready is stuck high
    d0 = done_cnt; e0 = err_cnt;
    send_cmd(1'b1, 8'h60, 4'd3);
    write_beat(8'h60, 16'hAAAA, 0);
    write_beat(8'h61, 16'h5555, 0);
    n = 0;
    while (valid && n < 50) begin @(negedge clk); n++; end
    check("beat2_release_reached", busy && !valid, 1);
    sram_mode = 2;
    #2 rst = 1'b0;
    #1;
    check("midrst_valid", valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_addr", addr, 0);
    check("midrst_wr_data", wr_data, 0);
    check("midrst_wr_rd", wr_rd, 0);
    check("midrst_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stale_ready_cmd_ready", cmd_ready, 0);
    end
    sram_mode = 0;
    @(negedge clk);
    check("ready_dropped_cmd_ready", cmd_ready, 1);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_no_err", err_cnt - e0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_master.md
# sram_master

Initiator for the single-port SRAM valid/ready protocol. Accepts single or burst read/write commands from a host-side command interface, sequences each beat as a full four-phase valid/ready handshake toward the SRAM, streams write data in and read data out, and flags unresponsive targets with a timeout. Its SRAM-side ports connect one-to-one to the SRAM responder's ports of the same names.

## Interface
- ADDR_W, 8, SRAM address width
- DATA_W, 16, SRAM data width
- TIMEOUT, 15, max cycles waited for any `ready` level change before abort (1..255)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  host command present
- cmd_ready  out  1  command accepted when both high; combinational: state==IDLE && ready==0
- cmd_wr  in  1  1=write burst, 0=read burst
- cmd_addr  in  ADDR_W  burst start address
- cmd_len  in  4  beats minus one (0..15 → 1..16 beats)
- wd_valid  in  1  write data available
- wd_ready  out  1  combinational: high only in FETCH
- wd_data  in  DATA_W  write data for current beat
- rsp_valid  out  1  read data valid (registered)
- rsp_ready  in  1  host takes read data
- rsp_data  out  DATA_W  read data
- rsp_last  out  1  with rsp_valid on final beat of a read burst
- done  out  1  one-cycle pulse, burst completed normally
- err  out  1  one-cycle pulse, burst aborted on timeout
- busy  out  1  state != IDLE
- addr  out  ADDR_W  SRAM address (registered)
- wr_data  out  DATA_W  SRAM write data (registered)
- wr_rd  out  1  SRAM direction, 1=write (registered)
- valid  out  1  SRAM request (registered)
- ready  in  1  SRAM acknowledge
- rd_data  in  DATA_W  SRAM read data

## Operation
- States: IDLE, FETCH, REQ, RELEASE, RESP.
- IDLE: on cmd handshake latch cmd_wr, cmd_addr, cmd_len; beat counter=0; addr<=cmd_addr, wr_rd<=cmd_wr. Write → FETCH; read → REQ with valid<=1.
- FETCH: wd_ready=1; on wd_valid capture wr_data<=wd_data, valid<=1 → REQ. No timeout in FETCH (waits indefinitely).
- REQ: hold valid/addr/wr_rd/wr_data stable until ready sampled 1; then valid<=0, on read rsp_data<=rd_data → RELEASE.
- RELEASE: wait for ready sampled 0 (target idle). Then: read → RESP (rsp_valid<=1, rsp_last<=last beat); write, more beats → FETCH; write, last beat → IDLE with done pulse.
- RESP: hold rsp_valid/rsp_data/rsp_last until rsp_ready sampled 1; then rsp_valid<=0; more beats → REQ (valid<=1, next addr); last → IDLE with done pulse.
- Address per beat = start + beat index, modulo 2^ADDR_W (0xFF wraps to 0x00).
- Timeout: counter clears on entering REQ or RELEASE, increments each cycle there; reaching TIMEOUT without the awaited `ready` level → valid<=0, rsp_valid<=0, err pulse, → IDLE. Remaining beats dropped; no further wd_ready for that burst. done never pulses on an aborted burst.
- cmd_ready gated on ready==0, so a stale `ready` after abort or reset is never mistaken for a new acknowledge.

## Timing
- Reset (rst low, async): state IDLE; valid, wr_rd, addr, wr_data, rsp_valid, rsp_data, rsp_last, done, err all 0; busy 0. Reset mid-burst abandons the burst without done/err.
- Read beat, zero stalls: edge E0 cmd accepted, valid=1; E1 SRAM ready=1; E2 master sees ready, captures rd_data, valid=0; E3 ready=0; E4 master sees ready=0, rsp_valid=1; with rsp_ready high, E5 rsp taken. 5 cycles/beat.
- Write beat, wd_valid held high: FETCH 1 cycle + REQ 2 + RELEASE 2 = 5 cycles/beat; first FETCH begins cycle after cmd accept.
- SRAM sees valid high on two consecutive edges per beat; operation repeats idempotently at same address/data.
- done/err asserted exactly one cycle, registered, the cycle the state returns to IDLE.
- cmd_valid while busy is ignored (cmd_ready=0).

## Test plan
- Write 0xBEEF to 0x10 (len 0), then read 0x10 → one wd handshake, done after write; rsp_data=0xBEEF, rsp_last=1, 5-cycle read beat, done pulse.
- Write burst len 3 from 0xFE with data 1,2,3,4 then read burst → SRAM addresses 0xFE,0xFF,0x00,0x01; read returns 1,2,3,4, rsp_last only on 4th.
- Read burst len 1 with rsp_ready low 10 cycles per beat → rsp_valid/rsp_data held stable, no second SRAM request until first rsp taken.
- Write with wd_valid low 7 cycles → valid stays 0, no err, beat completes after data arrives.
- SRAM ready tied 0, read at 0x20 → valid high TIMEOUT cycles, then valid=0, err pulse, no rsp_valid, no done; cmd_ready returns high.
- rst low during RELEASE of beat 2 of 4-beat write while SRAM ready=1 → outputs to reset values immediately; cmd_ready stays 0 until ready drops.
